// File: rtl/ecc_correct_controller.sv
// ecc_correct_controller
//   Compares the ECC computed over a freshly read 512-byte sector with the
//   ECC stored in the spare area. If exactly one data bit is flipped, it
//   fixes that bit in the sector buffer with one read-modify-write.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   en                  start pulse (only looked at in IDLE)
//   ecc_calc/ecc_stored 24-bit ECCs latched on start
//   data_in             buffer read data, valid the cycle after rd_en
//   addr                buffer word address {2'b00, byte[8:2]}
//   rd_en, wr_en        buffer strobes
//   data_out            corrected word, meaningful while wr_en=1
//   busy, done          activity flag / one-cycle completion pulse
//   status              00 clean, 01 corrected, 10 ECC-area error, 11 uncorrectable
//   err_byte, err_bit   location of the corrected bit (0 unless status=01)
module ecc_correct_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] ecc_calc,
  input  logic [23:0] ecc_stored,
  input  logic [31:0] data_in,
  output logic [8:0]  addr,
  output logic        rd_en,
  output logic        wr_en,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [8:0]  err_byte,
  output logic [2:0]  err_bit
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] calc_q, stored_q, syn;
  logic [11:0] pair_ok;
  logic        correctable, single_bit;
  logic [8:0]  syn_byte;
  logic [2:0]  syn_bit;
  logic [31:0] flip_mask, wdata_q;

  // Syndrome decode. A single data-bit error flips exactly one bit of every
  // parity pair; the odd bits of the pairs then spell out the bit location.
  always_comb begin
    syn     = calc_q ^ stored_q;
    pair_ok = '0;
    for (int i = 0; i < 12; i++) pair_ok[i] = syn[2*i] ^ syn[2*i+1];
    syn_byte = '0;
    for (int i = 0; i < 9; i++) syn_byte[i] = syn[2*i+7];
    syn_bit     = {syn[5], syn[3], syn[1]};
    correctable = &pair_ok;
    single_bit  = $onehot(syn);
  end

  // Bit position inside the word is 8*lane + bit, i.e. {lane, bit}.
  assign flip_mask = 32'd1 << {err_byte[1:0], err_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_q   <= '0;
      stored_q <= '0;
      status   <= 2'b00;
      err_byte <= '0;
      err_bit  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (en) begin
          calc_q   <= ecc_calc;
          stored_q <= ecc_stored;
        end
        S_CHECK: begin
          err_byte <= '0;
          err_bit  <= '0;
          if (syn == 24'd0) status <= 2'b00;
          else if (correctable) begin
            status   <= 2'b01;
            err_byte <= syn_byte;
            err_bit  <= syn_bit;
          end
          else if (single_bit) status <= 2'b10;
          else                 status <= 2'b11;
        end
        // Capture in WAIT: the buffer only guarantees data_in for the one
        // cycle after rd_en.
        S_WAIT:  wdata_q <= data_in ^ flip_mask;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (syn != 24'd0 && correctable) ? S_READ : S_DONE;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are pure state decodes, so reset silences them immediately.
  always_comb begin
    busy     = (state != S_IDLE);
    rd_en    = (state == S_READ);
    wr_en    = (state == S_WRITE);
    done     = (state == S_DONE);
    addr     = '0;
    data_out = '0;
    if (state == S_READ || state == S_WAIT || state == S_WRITE)
      addr = {2'b00, err_byte[8:2]};
    if (state == S_WRITE)
      data_out = wdata_q;
  end

endmodule

// File: doc/ecc_correct_controller.md
ECC_CORRECT_CONTROLLER -- requirements
Module: ecc_correct_controller

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 en  input  1  start pulse; sampled only in IDLE.
REQ-004 ecc_calc  input  24  ECC computed over the 512-byte sector just read.
REQ-005 ecc_stored  input  24  ECC read from the spare area for that sector.
REQ-006 data_in  input  32  sector buffer read data; valid one cycle after rd_en.
REQ-007 addr  output  9  buffer word address; bits [8:7] always 0, bits [6:0] equal byte address [8:2].
REQ-008 rd_en / wr_en  output  1 each  buffer read / write strobes.
REQ-009 data_out  output  32  corrected word written back when wr_en=1.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 status  output  2  00 no error, 01 corrected, 10 ECC-area error, 11 uncorrectable.
REQ-013 err_byte / err_bit  output  9 / 3  byte address and bit index of the corrected bit.

Function
REQ-014 Byte lane mapping: byte address b lies in word b[8:2], lane b[1:0]; lane 0 = data[7:0], lane 3 = data[31:24].
REQ-015 States: IDLE, CHECK, READ, WAIT, WRITE, DONE.
REQ-016 IDLE with en=1: latch ecc_calc and ecc_stored, then go to CHECK; en outside IDLE is ignored.
REQ-017 CHECK: syndrome syn = latched ecc_calc XOR latched ecc_stored (24 bits); pairs p_i = {syn[2i+1], syn[2i]} for i = 0..11.
REQ-018 syn = 0: status 00, next state DONE.
REQ-019 All 12 pairs equal 01 or 10: correctable; err_bit = {syn[5],syn[3],syn[1]}; err_byte = {syn[23],syn[21],...,syn[7]} (odd bits 23 down to 7); status 01; next state READ.
REQ-020 Otherwise, exactly one syndrome bit set: status 10, data untouched, next state DONE.
REQ-021 Any other syndrome: status 11, data untouched, next state DONE.
REQ-022 READ: addr = word address, rd_en = 1 for exactly one cycle; next state WAIT.
REQ-023 WAIT: rd_en = 0, addr held; next state WRITE.
REQ-024 WRITE: data_out = data_in XOR (1 << (8*err_byte[1:0] + err_bit)); wr_en = 1 for exactly one cycle, same addr; next state DONE.
REQ-025 DONE: done = 1 for one cycle; next state IDLE.
REQ-026 Latency, counted from the en-sampling edge: done is high in cycle 2 for the no-error and non-correctable paths, and in cycle 5 for the correctable path.
REQ-027 status, err_byte and err_bit stay stable from DONE until the next accepted en; err_byte and err_bit are 0 unless status = 01.
REQ-028 The buffer is accessed only when status = 01, with at most one read and one write per run.

Reset
REQ-029 While rst_n = 0, the block enters IDLE immediately and drives addr, rd_en, wr_en, data_out, busy, done, status, err_byte and err_bit to 0.
REQ-030 Reset in the middle of a run aborts it with no write; a pending wr_en is never issued after reset.

Verification
REQ-031 ecc_calc = ecc_stored = 24'h5A5A5A, en pulse -> no rd_en/wr_en, done in cycle 2, status 00.
REQ-032 Syndrome for byte 0x1FE bit 5, buffer word 0x7F = 32'h00FF0000 -> rd_en with addr 0x07F, then wr_en with data_out 32'h00DF0000; done in cycle 5, status 01, err_byte 0x1FE, err_bit 5.
REQ-033 syn = 24'h000100 -> status 10, no buffer access.
REQ-034 syn = 24'h000003 -> status 11, no buffer access.
REQ-035 en held high through a correctable run -> exactly one run, a single wr_en, then a new run starts after returning to IDLE.
REQ-036 rst_n driven low during WAIT -> all outputs 0 at once, no wr_en, next en runs normally.
